ver_query_init: RTL
===================

Name: ver_query_init

Overview:
- Initiator end of the UART "VER" query protocol; the host-side counterpart of the version responder.
- On a start pulse it transmits the fixed command "VER"<CR><LF> as 8N1 frames on TX.
- It then receives the responder's reply line on RX and stores it in an internal buffer, CR stripped, LF-terminated.
- It reports completion status and lets a host controller read the buffered reply.

Parameters:
- SLOOP_MAX, 100: clock cycles per UART bit period. Must be ≥4.
- DW, 8: UART data width. Fixed at 8 for this block.
- RBUF_AW, 4: reply buffer address width. Depth is 2**RBUF_AW bytes.
- TMO_CYC, 100000: cycles of RX inactivity allowed before a timeout.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a query. Ignored while busy=1.
- TX  out  1  UART serial out, idle high.
- RX  in  1  UART serial in, asynchronous.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  2  status: 00 ok, 01 timeout, 10 overflow, 11 framing. Held until the next accepted start.
- rlen  out  RBUF_AW+1  number of stored reply bytes.
- raddr  in  RBUF_AW  reply buffer read address.
- rdata  out  DW  buffer byte at raddr, registered, 1-cycle latency.

Behaviour:
- Reset (RST=1 at a CLK edge): TX=1, busy=0, done=0, err=00, rlen=0, state=IDLE, all counters 0. Buffer contents are not cleared.
- Reset mid-operation: TX returns to 1 on that edge and the current frame is truncated. No done pulse is issued.
- Frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly SLOOP_MAX cycles.
- States:
  - IDLE: on start=1, clear err and rlen, set busy, go to SEND.
  - SEND: drives 5 frames back-to-back with no idle gap: 0x56, 0x45, 0x52, 0x0D, 0x0A. TX goes low on the edge after start is sampled. After the last stop bit completes (5*10*SLOOP_MAX cycles), go to RX_WAIT with the timeout counter at 0.
  - RX_WAIT: RX passes through a 2-FF synchronizer. A high-to-low transition of the synchronized RX arms the receiver. RX edges outside RX_WAIT are ignored.
  - RX_WAIT timeout: the counter increments every cycle while no frame is in progress and resets at each byte's stop-bit sample. When it reaches TMO_CYC, go to FINISH with err=01.
  - RECV: samples the start bit at SLOOP_MAX/2 (integer division).
    - If the sampled start bit is 1, it is a glitch: go back to RX_WAIT without changing the timeout counter.
    - Otherwise sample each data bit and the stop bit one SLOOP_MAX apart.
    - Stop bit = 0: FINISH with err=11.
    - Byte 0x0D: discarded.
    - Byte 0x0A: FINISH with err=00.
    - Any other byte with rlen < 2**RBUF_AW: written to buffer[rlen], rlen++.
    - Any other byte with rlen = 2**RBUF_AW: FINISH with err=10; rlen stays at its maximum.
    - After any non-finishing byte, return to RX_WAIT. A new start bit may arrive immediately after the stop-bit sample.
  - FINISH: done=1 for one cycle, busy=0, go to IDLE.
- Simultaneous events:
  - start in the same cycle as FINISH is ignored.
  - A timeout that coincides with a start-bit edge loses: the frame is received.
- Buffer: single write port (receiver), single read port (raddr). rdata is registered. Reading during a query returns the current contents.

Decomposition:
- Shared package/header: the command byte constants (CMD_V, CMD_E, CMD_R, ASCII_CR, ASCII_LF) and the err encodings (ERR_OK, ERR_TMO, ERR_OVF, ERR_FRM). The responder uses the same definitions.
- One sub-module, uart_bit_engine: bit-period counter plus shift register, in TX and RX instances. The top level holds the FSM, command ROM index, timeout counter and buffer.

Test Plan (SLOOP_MAX=100, RBUF_AW=4, TMO_CYC=20000):
1. Command frames: pulse start → busy=1 on the next cycle; TX low 1 cycle after start. Decoded TX bytes are 0x56,0x45,0x52,0x0D,0x0A, with the final stop bit ending exactly 5000 cycles after the first start edge.
2. Normal reply: bench responder replies "1.0"<CR><LF> → single done pulse, err=00, rlen=3, rdata@0..2 = 0x31,0x2E,0x30.
3. No reply: silence after the command → done exactly 20000 cycles after RX_WAIT entry, err=01, rlen=0.
4. Overflow: reply of 17 printable bytes with no LF → done after the 17th stop sample, err=10, rlen=16, buffer holds the first 16 bytes.
5. Framing error: reply byte 0x41 with stop bit forced 0 → done, err=11, rlen=0.
6. Control: 20-cycle RX low glitch in RX_WAIT → ignored, no byte stored. start during busy → no restart. RST asserted mid-SEND → TX=1 and busy=0 next edge, no done pulse.

Source files
------------

// File: rtl/ver_query_init_pkg.sv
// Shared definitions for the UART "VER" query protocol (initiator and responder).
// Holds the command byte constants, the status encodings, the initiator FSM
// state type and a lookup for the command sequence "VER"<CR><LF>.
package ver_query_init_pkg;

  localparam logic [7:0] CMD_V    = 8'h56;
  localparam logic [7:0] CMD_E    = 8'h45;
  localparam logic [7:0] CMD_R    = 8'h52;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_TMO = 2'b01;
  localparam logic [1:0] ERR_OVF = 2'b10;
  localparam logic [1:0] ERR_FRM = 2'b11;

  // Index of the final command byte (LF)
  localparam logic [2:0] CMD_LAST = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_RX_WAIT,
    ST_RECV,
    ST_FINISH
  } state_e;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_byte = CMD_V;
      3'd1:    cmd_byte = CMD_E;
      3'd2:    cmd_byte = CMD_R;
      3'd3:    cmd_byte = ASCII_CR;
      default: cmd_byte = ASCII_LF;
    endcase
  endfunction

endpackage

// File: rtl/ver_query_init_uart_bit_engine.sv
// uart_bit_engine: bit-period counter plus shift register for one 8N1 frame.
// RX_MODE=0: transmitter. go_i loads din_i and drives the start bit on the
//   same edge; line_o is the registered serial output. fin_o pulses in the
//   last cycle of the stop bit so a new go_i there gives back-to-back frames.
// RX_MODE=1: receiver. go_i arms on a detected start edge; the start bit is
//   sampled SLOOP_MAX/2 cycles later, then data and stop one period apart.
//   bad_o pulses if the start sample is high; fin_o pulses at the stop sample
//   (stop value is rxd_i in that cycle) with the byte on data_o.
// Ports: clk_i, rst_i, go_i, din_i, rxd_i, line_o, data_o, fin_o, bad_o, active_o.
module uart_bit_engine #(
  parameter int SLOOP_MAX = 100,
  parameter int DW        = 8,
  parameter bit RX_MODE   = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          go_i,
  input  logic [DW-1:0] din_i,
  input  logic          rxd_i,
  output logic          line_o,
  output logic [DW-1:0] data_o,
  output logic          fin_o,
  output logic          bad_o,
  output logic          active_o
);

  localparam int CW = $clog2(SLOOP_MAX);
  localparam logic [CW-1:0] FULL = CW'(SLOOP_MAX - 1);
  localparam logic [CW-1:0] HALF = CW'(SLOOP_MAX / 2 - 1);
  localparam logic [3:0]    LAST = 4'(DW + 1);

  logic          act_q, act_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [DW-1:0] sh_q, sh_d;
  logic          line_q, line_d;
  logic          hit;

  // Receiver only waits half a period before the start-bit sample
  assign hit      = act_q && (cnt_q == ((RX_MODE && bit_q == 4'd0) ? HALF : FULL));
  assign fin_o    = hit && (bit_q == LAST);
  assign bad_o    = RX_MODE && hit && (bit_q == 4'd0) && rxd_i;
  assign line_o   = line_q;
  assign data_o   = sh_q;
  assign active_o = act_q;

  always_comb begin
    act_d  = act_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    line_d = line_q;
    if (act_q) cnt_d = hit ? '0 : cnt_q + 1'b1;
    if (hit) begin
      if (RX_MODE) begin
        if (bit_q == 4'd0) begin
          if (rxd_i) act_d = 1'b0;
          else       bit_d = 4'd1;
        end else if (bit_q == LAST) begin
          act_d = 1'b0;
        end else begin
          sh_d  = {rxd_i, sh_q[DW-1:1]};
          bit_d = bit_q + 4'd1;
        end
      end else begin
        if (bit_q == LAST) begin
          act_d  = 1'b0;
          line_d = 1'b1;
        end else begin
          // Ones shifted in behind the data supply the stop bit
          line_d = sh_q[0];
          sh_d   = {1'b1, sh_q[DW-1:1]};
          bit_d  = bit_q + 4'd1;
        end
      end
    end
    if (go_i) begin
      act_d = 1'b1;
      cnt_d = '0;
      bit_d = 4'd0;
      if (!RX_MODE) begin
        line_d = 1'b0;
        sh_d   = din_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_q  <= 1'b0;
      cnt_q  <= '0;
      bit_q  <= 4'd0;
      line_q <= 1'b1;
    end else begin
      act_q  <= act_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      line_q <= line_d;
    end
  end

  always_ff @(posedge clk_i) sh_q <= sh_d;

endmodule

// File: rtl/ver_query_init.sv
// ver_query_init: initiator of the UART "VER" query. On start it sends
// "VER"<CR><LF>, then collects the reply line (CR dropped, LF ends it) into a
// buffer of 2**RBUF_AW bytes and reports status.
// Ports: CLK, RST (sync, active-high), start, TX, RX (async), busy, done,
//   err (00 ok / 01 timeout / 10 overflow / 11 framing), rlen, raddr,
//   rdata (registered read of buffer[raddr]).
module ver_query_init
  import ver_query_init_pkg::*;
#(
  parameter int SLOOP_MAX = 100,
  parameter int DW        = 8,
  parameter int RBUF_AW   = 4,
  parameter int TMO_CYC   = 100000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  output logic               TX,
  input  logic               RX,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err,
  output logic [RBUF_AW:0]   rlen,
  input  logic [RBUF_AW-1:0] raddr,
  output logic [DW-1:0]      rdata
);

  localparam int DEPTH = 2 ** RBUF_AW;
  localparam int TW    = $clog2(TMO_CYC + 1);

  state_e               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [1:0]           err_q, err_d;
  logic [RBUF_AW:0]     rlen_q, rlen_d;
  logic                 rx_s1_q, rx_s2_q, rx_s3_q;
  logic                 rx_fall;
  logic [DW-1:0]        mem_q [DEPTH];
  logic [DW-1:0]        rdata_q;
  logic                 wr_en;
  logic                 tx_go, tx_fin, tx_line, tx_bad, tx_act;
  logic [DW-1:0]        tx_din, tx_data;
  logic                 rx_go, rx_fin, rx_bad, rx_line, rx_act;
  logic [DW-1:0]        rx_byte;
  logic                 unused_ok;

  uart_bit_engine #(.SLOOP_MAX(SLOOP_MAX), .DW(DW), .RX_MODE(1'b0)) u_tx (
    .clk_i(CLK), .rst_i(RST), .go_i(tx_go), .din_i(tx_din), .rxd_i(1'b1),
    .line_o(tx_line), .data_o(tx_data), .fin_o(tx_fin), .bad_o(tx_bad),
    .active_o(tx_act)
  );

  uart_bit_engine #(.SLOOP_MAX(SLOOP_MAX), .DW(DW), .RX_MODE(1'b1)) u_rx (
    .clk_i(CLK), .rst_i(RST), .go_i(rx_go), .din_i('0), .rxd_i(rx_s2_q),
    .line_o(rx_line), .data_o(rx_byte), .fin_o(rx_fin), .bad_o(rx_bad),
    .active_o(rx_act)
  );

  assign unused_ok = &{1'b0, tx_data, tx_bad, tx_act, rx_line, rx_act};

  // s3 holds the previous synchronized value for edge detection
  assign rx_fall = rx_s3_q & ~rx_s2_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    rlen_d  = rlen_q;
    tx_go   = 1'b0;
    tx_din  = CMD_V;
    rx_go   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d   = ERR_OK;
          rlen_d  = '0;
          idx_d   = 3'd0;
          tx_go   = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_fin) begin
          if (idx_q == CMD_LAST) begin
            tmo_d   = '0;
            state_d = ST_RX_WAIT;
          end else begin
            idx_d  = idx_q + 3'd1;
            tx_din = cmd_byte(idx_q + 3'd1);
            tx_go  = 1'b1;
          end
        end
      end
      ST_RX_WAIT: begin
        // A start edge wins over a coincident timeout
        if (rx_fall) begin
          rx_go   = 1'b1;
          state_d = ST_RECV;
        end else if (tmo_q == TW'(TMO_CYC - 1)) begin
          err_d   = ERR_TMO;
          state_d = ST_FINISH;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_RECV: begin
        if (rx_bad) begin
          state_d = ST_RX_WAIT;
        end else if (rx_fin) begin
          tmo_d   = '0;
          state_d = ST_RX_WAIT;
          if (!rx_s2_q) begin
            err_d   = ERR_FRM;
            state_d = ST_FINISH;
          end else if (rx_byte == ASCII_LF) begin
            err_d   = ERR_OK;
            state_d = ST_FINISH;
          end else if (rx_byte != ASCII_CR) begin
            if (rlen_q == (RBUF_AW + 1)'(DEPTH)) begin
              err_d   = ERR_OVF;
              state_d = ST_FINISH;
            end else begin
              wr_en  = 1'b1;
              rlen_d = rlen_q + 1'b1;
            end
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      tmo_q   <= '0;
      err_q   <= ERR_OK;
      rlen_q  <= '0;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      rlen_q  <= rlen_d;
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[rlen_q[RBUF_AW-1:0]] <= rx_byte;
    rdata_q <= mem_q[raddr];
  end

  assign TX    = tx_line;
  assign busy  = (state_q == ST_SEND) || (state_q == ST_RX_WAIT) || (state_q == ST_RECV);
  assign done  = (state_q == ST_FINISH);
  assign err   = err_q;
  assign rlen  = rlen_q;
  assign rdata = rdata_q;

endmodule
